// File: rtl/tmds_channel_encoder_pkg.sv
// Shared TMDS definitions: control-period tokens and parameter legality helpers
// used by every channel encoder instance.
package tmds_channel_encoder_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  // {c1,c0} selects the blanking token.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = TMDS_CTRL_00;
      2'b01:   tok = TMDS_CTRL_01;
      2'b10:   tok = TMDS_CTRL_10;
      default: tok = TMDS_CTRL_11;
    endcase
    return tok;
  endfunction

  function automatic bit in_width_legal(input int w);
    return (w == 6) || (w == 8);
  endfunction

  function automatic bit channel_legal(input int ch);
    return (ch >= 0) && (ch <= 2);
  endfunction

endpackage

// File: rtl/tmds_channel_encoder_popcount8.sv
// 8-bit population count, purely combinational. Shared by both encoder stages.
module tmds_popcount8 (
  input  logic [7:0] i_bits,
  output logic [3:0] o_count
);

  always_comb begin
    // NOTE: default first, so every path assigns o_count and no latch is inferred.
    o_count = '0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_bits[i]};
    end
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder: colour scaling, transition minimisation (stage 1),
// DC balancing with running disparity or control tokens (stage 2).
module tmds_channel_encoder
  import tmds_channel_encoder_pkg::*;
#(
  parameter int IN_WIDTH = 6,
  parameter int CHANNEL  = 0
) (
  input  logic                clk_dot4x,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] din,
  input  logic                de,
  input  logic                c0,
  input  logic                c1,
  output logic [9:0]          tmds_out
);

  if (!in_width_legal(IN_WIDTH)) begin : g_bad_in_width
    $error("tmds_channel_encoder: IN_WIDTH must be 6 or 8");
  end
  if (!channel_legal(CHANNEL)) begin : g_bad_channel
    $error("tmds_channel_encoder: CHANNEL must be 0, 1 or 2");
  end

  // Bit replication maps 0 -> 0x00 and 63 -> 0xFF exactly.
  logic [7:0] w_d;
  if (IN_WIDTH == 6) begin : g_scale6
    assign w_d = {din, din[5:4]};
  end else begin : g_pass8
    assign w_d = din[7:0];
  end

  logic [3:0] w_n1d;
  logic       w_use_xnor;
  logic [8:0] w_qm;

  tmds_popcount8 u_pop_d (
    .i_bits  (w_d),
    .o_count (w_n1d)
  );

  assign w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_d[0]);

  always_comb begin
    logic [8:0] v_qm;
    v_qm    = '0;
    v_qm[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      v_qm[i] = w_use_xnor ? ~(v_qm[i-1] ^ w_d[i]) : (v_qm[i-1] ^ w_d[i]);
    end
    v_qm[8] = ~w_use_xnor;
    w_qm    = v_qm;
  end

  logic [8:0] r_qm;
  logic       r_de;
  logic [1:0] r_c;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      r_qm <= '0;
      r_de <= 1'b0;
      r_c  <= 2'b00;
    end else begin
      r_qm <= w_qm;
      r_de <= de;
      r_c  <= {c1, c0};
    end
  end

  logic        [3:0] w_n1q;
  logic signed [5:0] w_diff;
  logic signed [5:0] w_cnt_x;
  logic signed [5:0] w_cnt_nx;
  logic        [9:0] w_sym;
  logic signed [4:0] r_cnt;
  logic        [9:0] r_tmds;

  tmds_popcount8 u_pop_q (
    .i_bits  (r_qm[7:0]),
    .o_count (w_n1q)
  );

  // n1q - n0q = 2*n1q - 8; six bits keep the intermediate sums from wrapping.
  assign w_diff  = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;
  assign w_cnt_x = {r_cnt[4], r_cnt};

  always_comb begin
    w_sym    = ctrl_token(r_c);
    w_cnt_nx = '0;
    if (r_de) begin
      if ((r_cnt == 5'sd0) || (w_diff == 6'sd0)) begin
        w_sym    = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt_nx = r_qm[8] ? (w_cnt_x + w_diff) : (w_cnt_x - w_diff);
      end else if ((!r_cnt[4] && (w_diff > 6'sd0)) || (r_cnt[4] && (w_diff < 6'sd0))) begin
        w_sym    = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_nx = w_cnt_x + (r_qm[8] ? 6'sd2 : 6'sd0) - w_diff;
      end else begin
        w_sym    = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_nx = w_cnt_x - (r_qm[8] ? 6'sd0 : 6'sd2) + w_diff;
      end
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      r_tmds <= TMDS_CTRL_00;
      r_cnt  <= '0;
    end else begin
      r_tmds <= w_sym;
      r_cnt  <= w_cnt_nx[4:0];
    end
  end

  assign tmds_out = r_tmds;

  // The balancing rules keep disparity within +/-10, so the 5-bit counter never wraps.
  a_cnt_range : assert property (@(posedge clk_dot4x) disable iff (rst)
    (w_cnt_nx >= -6'sd10) && (w_cnt_nx <= 6'sd10));

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: spec vector table, model-driven
// sweeps/random traffic, and de-drop / mid-line reset sequences, via a scoreboard.
module tb_tmds_channel_encoder;

  logic       clk_dot4x = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] din = '0;
  logic       de = 1'b0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic [9:0] tmds_out;

  tmds_channel_encoder #(
    .IN_WIDTH (6),
    .CHANNEL  (0)
  ) dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .din       (din),
    .de        (de),
    .c0        (c0),
    .c1        (c1),
    .tmds_out  (tmds_out)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  typedef struct {
    string      name;
    logic [9:0] exp;
    logic       data;
    logic [7:0] exp_d;
    logic       has_cnt;
    int         exp_cnt;
  } sb_t;

  typedef struct {
    string      name;
    logic [5:0] din;
    logic       de;
    logic [1:0] c;
    logic [9:0] exp;
    logic       has_cnt;
    int         exp_cnt;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt = 0;
  int   run_sum = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder written from the algorithm in plain integers.
  function automatic logic [9:0] model_sym(input logic [7:0] d, input logic e, input logic [1:0] c);
    int         n1, ones, zeros, q8;
    bit         use_xnor;
    logic [8:0] qm;
    logic [9:0] sym;
    if (!e) begin
      m_cnt = 0;
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      return sym;
    end
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    q8 = use_xnor ? 0 : 1;
    ones = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (m_cnt == 0 || ones == zeros) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_cnt = m_cnt + ((q8 == 1) ? (ones - zeros) : (zeros - ones));
    end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      m_cnt = m_cnt + 2 * q8 + (zeros - ones);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      m_cnt = m_cnt - 2 * (1 - q8) + (ones - zeros);
    end
    return sym;
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic int disp(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  // One clock of stimulus; the result surfaces two edges later. A reset turns
  // the in-flight symbol and this cycle's symbol into the idle token.
  task automatic step(input logic r, input logic [5:0] d, input logic e, input logic [1:0] c,
                      input logic use_exp, input logic [9:0] exp, input logic has_cnt,
                      input int exp_cnt, input string name);
    sb_t        ent, prev;
    logic [9:0] m;
    @(negedge clk_dot4x);
    rst = r; din = d; de = e; c1 = c[1]; c0 = c[0];
    ent.exp_cnt = 0;
    if (r) begin
      m_cnt = 0;
      if (sb.size() > 0) begin
        prev = sb.pop_back();
        prev.exp = 10'h354;
        prev.data = 1'b0;
        prev.has_cnt = 1'b0;
        prev.name = {prev.name, "_rst"};
        sb.push_back(prev);
      end
      ent.name = "rst_pipe"; ent.exp = 10'h354; ent.data = 1'b0;
      ent.exp_d = '0; ent.has_cnt = 1'b0;
    end else begin
      m = model_sym({d, d[5:4]}, e, c);
      ent.name = name; ent.exp = use_exp ? exp : m; ent.data = e;
      ent.exp_d = {d, d[5:4]}; ent.has_cnt = has_cnt; ent.exp_cnt = exp_cnt;
    end
    sb.push_back(ent);
    @(posedge clk_dot4x);
    #1;
    if (r) check("rst_now", tmds_out, 10'h354);
    if (sb.size() == 2) begin
      ent = sb.pop_front();
      check(ent.name, tmds_out, ent.exp);
      if (ent.data) begin
        check({ent.name, "_dec"}, dec(tmds_out), ent.exp_d);
        run_sum += disp(tmds_out);
        check("disp_range", (run_sum >= -10 && run_sum <= 10), 1);
        if (ent.has_cnt) check({ent.name, "_cnt"}, run_sum, ent.exp_cnt);
      end else begin
        run_sum = 0;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 2'b00, 1'b0, 10'h0, 1'b0, 0, "idle");
  endtask

  task automatic white(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 6'd63, 1'b1, 2'b00, 1'b0, 10'h0, 1'b0, 0, "white_run");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tbl.push_back('{"tok00", 6'd0, 1'b0, 2'b00, 10'h354, 1'b0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{"tok01", 6'd0, 1'b0, 2'b01, 10'h0AB, 1'b0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{"tok10", 6'd0, 1'b0, 2'b10, 10'h154, 1'b0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{"tok11", 6'd0, 1'b0, 2'b11, 10'h2AB, 1'b0, 0});
    tbl.push_back('{"black0", 6'd0,  1'b1, 2'b00, 10'h100, 1'b1, -8});
    tbl.push_back('{"black1", 6'd0,  1'b1, 2'b00, 10'h3FF, 1'b1,  2});
    tbl.push_back('{"black2", 6'd0,  1'b1, 2'b00, 10'h100, 1'b1, -6});
    tbl.push_back('{"black3", 6'd0,  1'b1, 2'b00, 10'h3FF, 1'b1,  4});
    tbl.push_back('{"gap_bw", 6'd0,  1'b0, 2'b00, 10'h354, 1'b0,  0});
    tbl.push_back('{"white0", 6'd63, 1'b1, 2'b00, 10'h200, 1'b1, -8});
    tbl.push_back('{"white1", 6'd63, 1'b1, 2'b00, 10'h0FF, 1'b1, -2});
    tbl.push_back('{"white2", 6'd63, 1'b1, 2'b00, 10'h0FF, 1'b1,  4});
    tbl.push_back('{"white3", 6'd63, 1'b1, 2'b00, 10'h200, 1'b1, -4});
    tbl.push_back('{"gap_end", 6'd0, 1'b0, 2'b00, 10'h354, 1'b0,  0});

    for (int i = 0; i < 3; i++)
      step(1'b1, 6'($urandom), 1'($urandom), 2'($urandom), 1'b0, 10'h0, 1'b0, 0, "rst");
    step(1'b0, 6'd0, 1'b1, 2'b00, 1'b1, 10'h100, 1'b1, -8, "post_rst_black");
    idle();

    foreach (tbl[i])
      step(1'b0, tbl[i].din, tbl[i].de, tbl[i].c, 1'b1, tbl[i].exp, tbl[i].has_cnt,
           tbl[i].exp_cnt, tbl[i].name);

    for (int v = 0; v < 64; v++)
      step(1'b0, 6'(v), 1'b1, 2'b00, 1'b0, 10'h0, 1'b0, 0, "sweep");
    idle();

    for (int i = 0; i < 150; i++)
      step(1'b0, 6'($urandom), ($urandom_range(0, 9) < 8), 2'($urandom), 1'b0, 10'h0,
           1'b0, 0, "random");
    idle();

    white(5);
    step(1'b0, 6'd0, 1'b0, 2'b00, 1'b0, 10'h0, 1'b0, 0, "de_drop_gap");
    step(1'b0, 6'd0, 1'b1, 2'b00, 1'b1, 10'h100, 1'b1, -8, "de_drop_restart");

    white(5);
    step(1'b1, 6'd63, 1'b1, 2'b00, 1'b0, 10'h0, 1'b0, 0, "rst_mid");
    step(1'b0, 6'd0, 1'b1, 2'b00, 1'b1, 10'h100, 1'b1, -8, "rst_restart");

    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
